// File: rtl/sram_port_driver_pkg.sv
// Shared widths, FSM state and request record for the RW0 SRAM port driver.
package sram_port_pkg;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/sram_port_driver_if.sv
// Request/response channels plus the RW0 macro port; master = L2 side and macro model,
// slave = the port driver.
interface sram_port_driver_if;
  import sram_port_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [MASK_W-1:0] req_mask;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              init_done;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  modport master (
    output req_valid, req_addr, req_write, req_mask, req_data, resp_ready, RW0_rdata,
    input  req_ready, resp_valid, resp_data, init_done,
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_mask, req_data, resp_ready, RW0_rdata,
    output req_ready, resp_valid, resp_data, init_done,
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );

endinterface

// File: rtl/sram_resp_fifo.sv
// Circular read-response buffer; head entry is presented straight from registered storage.
module sram_resp_fifo #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                push,
  input  logic [DATA_W-1:0]                   push_data,
  input  logic                                pop,
  output logic [DATA_W-1:0]                   head_data,
  output logic [$clog2(RESP_DEPTH+1)-1:0]     count,
  output logic                                full,
  output logic                                empty
);

  localparam int unsigned PtrW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [RESP_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
    return (p == PtrW'(RESP_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= bump(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= bump(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = (count_q == CntW'(RESP_DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/sram_port_driver.sv
// RW0 SRAM port initiator with credit-gated reads and in-order responses.
// Define SRAM_PORT_INIT_EN to clear INIT_DEPTH addresses after reset before accepting requests.
module sram_port_driver
  import sram_port_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RESP_DEPTH   = 2,
  parameter int unsigned INIT_DEPTH   = 2 ** ADDR_W
) (
  input logic               clock,
  input logic               reset_n,
  sram_port_driver_if.slave bus
);

  localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 4 || RESP_DEPTH < READ_LATENCY + 1 ||
      INIT_DEPTH < 1 || INIT_DEPTH > 2 ** ADDR_W) begin : g_bad_param
    $error("sram_port_driver: illegal parameter combination");
  end

  req_t                    req;
  logic                    fire, rd_fire, pop, push;
  logic                    init_done_q;
  logic [READ_LATENCY-1:0] pipe_q;
  logic [CntW-1:0]         fifo_count;
  logic                    fifo_full, fifo_empty;
  int unsigned             credits;

  assign req = '{addr: bus.req_addr, write: bus.req_write, mask: bus.req_mask,
                 data: bus.req_data};

  // A pop this cycle frees its entry in time for a read firing now, keeping full throughput.
  always_comb begin
    credits = 32'(fifo_count) - 32'(pop);
    for (int i = 0; i < READ_LATENCY; i++) credits += 32'(pipe_q[i]);
  end

  assign bus.req_ready = init_done_q && (credits < RESP_DEPTH);
  assign fire          = bus.req_valid && bus.req_ready;
  assign rd_fire       = fire && !req.write;

`ifdef SRAM_PORT_INIT_EN
  state_e            state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              init_en_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_en_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (!init_en_q) begin
            init_en_q <= 1'b1;
          end else if (init_cnt_q == ADDR_W'(INIT_DEPTH - 1)) begin
            init_en_q   <= 1'b0;
            init_done_q <= 1'b1;
            state_q     <= ST_RUN;
          end else begin
            init_cnt_q <= init_cnt_q + ADDR_W'(1);
          end
        end
        ST_RUN: init_done_q <= 1'b1;
      endcase
    end
  end
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) init_done_q <= 1'b0;
    else          init_done_q <= 1'b1;
  end
`endif

  always_comb begin
    bus.RW0_en    = 1'b0;
    bus.RW0_wmode = 1'b0;
    bus.RW0_addr  = '0;
    bus.RW0_wmask = '0;
    bus.RW0_wdata = '0;
    if (fire) begin
      bus.RW0_en    = 1'b1;
      bus.RW0_wmode = req.write;
      bus.RW0_addr  = req.addr;
      if (req.write) begin
        bus.RW0_wmask = req.mask;
        bus.RW0_wdata = req.data;
      end
    end
`ifdef SRAM_PORT_INIT_EN
    else if (init_en_q) begin
      bus.RW0_en    = 1'b1;
      bus.RW0_wmode = 1'b1;
      bus.RW0_addr  = init_cnt_q;
      bus.RW0_wmask = '1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= rd_fire;
      for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign push = pipe_q[READ_LATENCY-1];
  assign pop  = !fifo_empty && bus.resp_ready;

  sram_resp_fifo #(
    .DATA_W     (DATA_W),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (bus.RW0_rdata),
    .pop       (pop),
    .head_data (bus.resp_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.resp_valid = !fifo_empty;
  assign bus.init_done  = init_done_q;

  a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset_n)
    push |-> !fifo_full);

endmodule

// File: tb/tb_sram_port_driver.sv
// Directed bench for sram_port_driver with a behavioural RW0 macro; expectations follow
// SRAM_PORT_INIT_EN when it is defined for the build.
module tb_sram_port_driver;
  import sram_port_pkg::*;

  localparam int unsigned TbInitDepth = 8;
`ifdef SRAM_PORT_INIT_EN
  localparam int unsigned ExpInitCyc    = TbInitDepth + 1;
  localparam int unsigned ExpInitWrites = TbInitDepth;
`else
  localparam int unsigned ExpInitCyc    = 1;
  localparam int unsigned ExpInitWrites = 0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  sram_port_driver_if bus ();

  sram_port_driver #(
    .READ_LATENCY (1),
    .RESP_DEPTH   (2),
    .INIT_DEPTH   (TbInitDepth)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Single-port macro, one-cycle read latency, byte-masked writes.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  always @(posedge clock) begin : macro_model
    logic [DATA_W-1:0] cur;
    if (bus.RW0_en) begin
      cur = mem.exists(bus.RW0_addr) ? mem[bus.RW0_addr] : '0;
      if (bus.RW0_wmode) begin
        for (int b = 0; b < MASK_W; b++)
          if (bus.RW0_wmask[b]) cur[8*b +: 8] = bus.RW0_wdata[8*b +: 8];
        mem[bus.RW0_addr] = cur;
      end else begin
        bus.RW0_rdata <= cur;
      end
    end
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] fill(input logic [7:0] b);
    return {MASK_W{b}};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m,
                       input logic [DATA_W-1:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_mask  = m;
    bus.req_data  = d;
    #1;
    while (!bus.req_ready && n < 20) begin
      step();
      n++;
    end
    check("issue_ready", bus.req_ready, 1'b1);
    check("rw0_en", bus.RW0_en, 1'b1);
    check("rw0_addr", bus.RW0_addr, a);
    check("rw0_wmode", bus.RW0_wmode, w);
    check("rw0_wmask", bus.RW0_wmask, w ? m : '0);
    check("rw0_wdata", bus.RW0_wdata, w ? d : '0);
    step();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_mask  = '0;
    bus.req_data  = '0;
  endtask

  // Read with empty pipe and FIFO: response visible exactly two cycles after the fire.
  task automatic read_expect(input string tag, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] exp);
    issue(1'b0, a, '1, fill(8'hEE));
    check({tag, "_not_yet"}, bus.resp_valid, 1'b0);
    step();
    check({tag, "_valid"}, bus.resp_valid, 1'b1);
    check({tag, "_data"}, bus.resp_data, exp);
    step();
    check({tag, "_popped"}, bus.resp_valid, 1'b0);
  endtask

  initial begin
    int unsigned cyc, n_init, early, fires, r, dup, stalls, first, last, maxcnt, i, stale;
    logic [DATA_W-1:0] exp;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_mask   = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;
    reset_n        = 1'b0;

    #12;
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_init_done", bus.init_done, 1'b0);
    check("rst_rw0_en", bus.RW0_en, 1'b0);
    check("rst_rw0_addr", bus.RW0_addr, '0);
    check("rst_rw0_wmask", bus.RW0_wmask, '0);
    check("rst_rw0_wdata", bus.RW0_wdata, '0);

    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0; n_init = 0; early = 0;
    while (!bus.init_done && cyc < 100) begin
      step();
      cyc++;
      if (!bus.init_done) begin
        if (bus.req_ready) early++;
        if (bus.RW0_en) begin
          check("init_addr", bus.RW0_addr, n_init);
          check("init_wmode", bus.RW0_wmode, 1'b1);
          check("init_wmask", bus.RW0_wmask, '1);
          check("init_wdata", bus.RW0_wdata, '0);
          n_init++;
        end
      end
    end
    check("init_done_cycle", cyc, ExpInitCyc);
    check("init_writes", n_init, ExpInitWrites);
    check("ready_during_init", early, 0);
    check("ready_after_init", bus.req_ready, 1'b1);
    check("rw0_idle", bus.RW0_en, 1'b0);

    issue(1'b1, 19'h1234, '1, fill(8'hA5));
    read_expect("basic", 19'h1234, fill(8'hA5));

    issue(1'b1, 19'h0055, '1, fill(8'h11));
    issue(1'b1, 19'h0055, 32'h0000_000F, fill(8'h22));
    exp = fill(8'h11);
    exp[31:0] = 32'h2222_2222;
    read_expect("pmask", 19'h0055, exp);

    for (int k = 1; k <= 4; k++) issue(1'b1, 19'(k), '1, fill(8'(176 + k)));
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 19'd1;
    #1;
    fires = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.req_ready) fires++;
      step();
      if (fires < 4) bus.req_addr = 19'(1 + fires);
    end
    check("bp_fires", fires, 2);
    check("bp_ready_low", bus.req_ready, 1'b0);
    check("bp_head_valid", bus.resp_valid, 1'b1);
    check("bp_head_data", bus.resp_data, fill(8'hB1));
    bus.resp_ready = 1'b1;
    #1;
    r = 0;
    for (int c = 0; c < 40 && r < 4; c++) begin
      if (bus.resp_valid) begin
        check("bp_data", bus.resp_data, fill(8'(177 + r)));
        r++;
      end
      if (fires < 4 && bus.req_ready) fires++;
      step();
      if (fires < 4) bus.req_addr = 19'(1 + fires);
      else bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    check("bp_resp_count", r, 4);
    check("bp_all_fired", fires, 4);
    dup = 0;
    repeat (6) begin
      step();
      if (bus.resp_valid) dup++;
    end
    check("bp_no_dup", dup, 0);

    for (int k = 0; k < 16; k++) issue(1'b1, 19'(256 + k), '1, fill(8'(64 + k)));
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 19'd256;
    #1;
    i = 0; r = 0; stalls = 0; first = 0; last = 0; maxcnt = 0;
    for (int c = 0; c < 40 && r < 16; c++) begin
      if (bus.resp_valid) begin
        check("tp_data", bus.resp_data, fill(8'(64 + r)));
        if (r == 0) first = c;
        last = c;
        r++;
      end
      if (32'(dut.u_fifo.count) > maxcnt) maxcnt = 32'(dut.u_fifo.count);
      if (i < 16) begin
        if (bus.req_ready) i++;
        else stalls++;
      end
      step();
      if (i < 16) bus.req_addr = 19'(256 + i);
      else bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    check("tp_stalls", stalls, 0);
    check("tp_resp_count", r, 16);
    check("tp_first_latency", first, 2);
    check("tp_back_to_back", last - first, 15);
    check("tp_max_count", maxcnt, 1);

    step();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 19'd1;
    step();
    bus.req_addr = 19'd2;
    step();
    bus.req_addr = 19'd3;
    #1;
    check("mid_resp_valid", bus.resp_valid, 1'b1);
    check("mid_rw0_en", bus.RW0_en, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", bus.resp_valid, 1'b0);
    check("mid_rst_rw0_en", bus.RW0_en, 1'b0);
    check("mid_rst_req_ready", bus.req_ready, 1'b0);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    stale = 0;
    for (int c = 0; c < int'(ExpInitCyc) + 20; c++) begin
      step();
      if (bus.resp_valid) stale++;
    end
    check("rst_no_stale", stale, 0);
    check("rst_init_again", bus.init_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
